// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding used by both the transmitter
// and the receiver, default oversampling ratio and parity-mode constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int OVERSAMPLE_DEF = 16;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

  // Counter width that stays legal for a terminal count of 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Handshake/serial bundle between a UART transmit client and uart_tx.
interface uart_tx_if #(parameter int DATA_BITS = 8);
  logic                 baud_rate_tick;
  logic                 i_tx_start;
  logic [DATA_BITS-1:0] i_tx_data;
  logic                 o_tx;
  logic                 o_tx_busy;
  logic                 o_tx_done;

  modport master (output baud_rate_tick, i_tx_start, i_tx_data,
                  input  o_tx, o_tx_busy, o_tx_done);
  modport slave  (input  baud_rate_tick, i_tx_start, i_tx_data,
                  output o_tx, o_tx_busy, o_tx_done);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS LSB-first, optional parity, 1-2 stop
// bits, each OVERSAMPLE baud ticks long. All outputs registered.
module uart_tx import uart_pkg::*; #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = PAR_EVEN,
  parameter int STOP_BITS  = 1
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave bus
);

  localparam int TW = cnt_w(OVERSAMPLE);
  localparam int BW = cnt_w(DATA_BITS);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  uart_state_e          state, state_n;
  logic [TW-1:0]        tick_cnt, tick_cnt_n;
  logic [BW-1:0]        bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par, par_n;
  logic                 tx, tx_n;
  logic                 busy, busy_n;
  logic                 done, done_n;
  logic                 bit_end;

  assign bit_end = bus.baud_rate_tick && (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      par      <= par_n;
      tx       <= tx_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    par_n      = par;
    if (state != IDLE && bus.baud_rate_tick)
      tick_cnt_n = bit_end ? '0 : tick_cnt + 1'b1;
    case (state)
      IDLE: if (bus.i_tx_start) begin
        state_n    = START;
        shreg_n    = bus.i_tx_data;
        par_n      = (^bus.i_tx_data) ^ (PARITY_ODD != 0);
        tick_cnt_n = '0;
        bit_cnt_n  = '0;
      end
      START: if (bit_end) begin
        state_n   = DATA;
        bit_cnt_n = '0;
      end
      DATA: if (bit_end) begin
        shreg_n = shreg >> 1;
        if (bit_cnt == BIT_LAST) begin
          state_n   = (PARITY_EN != 0) ? PARITY : STOP;
          bit_cnt_n = '0;
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      PARITY: if (bit_end) state_n = STOP;
      // bit_cnt is reused to count stop bits
      STOP: if (bit_end) begin
        if (bit_cnt == STOP_LAST) state_n = IDLE;
        else                      bit_cnt_n = bit_cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register with it.
  always_comb begin
    busy_n = (state_n != IDLE);
    done_n = (state == STOP) && (state_n == IDLE);
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
  end

  assign bus.o_tx      = tx;
  assign bus.o_tx_busy = busy;
  assign bus.o_tx_done = done;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter; the transmit-side counterpart of the UART receiver in the PC-command path of the clock design.
- Shares the same 16x oversampling baud_rate_tick as the receiver.
- Accepts one parallel byte per start request and drives the framed bit stream (start, data LSB-first, optional parity, stop) on the TX line.
- Reports busy while a frame is in flight and pulses done at completion.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..8).
- OVERSAMPLE, 16, baud ticks per bit period.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- baud_rate_tick  in  1  one-clk-wide strobe at OVERSAMPLE x baud rate.
- i_tx_start  in  1  frame request; sampled every clk cycle.
- i_tx_data  in  DATA_BITS  byte to send; captured when the request is accepted.
- o_tx  out  1  serial line; idle high.
- o_tx_busy  out  1  high from acceptance until the last stop bit ends.
- o_tx_done  out  1  one-clk pulse when a frame completes.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high. All outputs are registered.
- Reset values: o_tx = 1, o_tx_busy = 0, o_tx_done = 0, state = IDLE, tick counter = 0, bit counter = 0, shift register = 0.
- States:
  - IDLE: o_tx = 1, busy = 0. If i_tx_start = 1, latch i_tx_data into the shift register and compute the parity bit (XOR of the data, inverted when PARITY_ODD = 1); go to START. Acceptance does not wait for a tick.
  - START: o_tx = 0. Tick counter advances only on baud_rate_tick. On a tick with counter = OVERSAMPLE-1, clear the counter and go to DATA with bit counter = 0.
  - DATA: o_tx = shift register bit 0. At each bit end (tick with counter = OVERSAMPLE-1), shift right. After bit DATA_BITS-1, go to PARITY if PARITY_EN, else STOP.
  - PARITY: o_tx = parity bit for OVERSAMPLE ticks, then go to STOP.
  - STOP: o_tx = 1 for STOP_BITS x OVERSAMPLE ticks. On the final tick, go to IDLE, assert o_tx_done for exactly one clk and drop o_tx_busy.
- Timing: o_tx and o_tx_busy change on the clk edge that registers the state change, so o_tx falls one clk after the request is accepted. The start bit spans exactly OVERSAMPLE ticks counted from the first tick after acceptance. The sub-tick gap before that first tick is part of the start bit.
- Frame length: (1 + DATA_BITS + PARITY_EN + STOP_BITS) x OVERSAMPLE ticks.
- Boundary conditions:
  - i_tx_start while busy: ignored; the latched data is unchanged and no queueing occurs.
  - i_tx_start held high continuously: back-to-back frames. The next frame is accepted in the first IDLE cycle, which is the same cycle o_tx_done is high. At least one clk of idle-high precedes the next start bit.
  - i_tx_data changing mid-frame: no effect on the frame in flight.
  - baud_rate_tick absent: the FSM holds its state and o_tx holds its level.
  - reset mid-frame: abort. The cycle after reset, o_tx = 1, busy = 0 and done = 0; no done pulse is generated for the aborted frame.
- Counter widths: tick counter is clog2(OVERSAMPLE) bits; bit counter is clog2(DATA_BITS) bits. Both are compared for equality only and never wrap past their terminal count.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding IDLE/START/DATA/PARITY/STOP, shared with the receiver;
  - OVERSAMPLE default 16;
  - parity-mode constants.
- No sub-module; a single FSM plus datapath. The baud tick generator already exists and is instantiated at top level.

Test Plan:
- 8N1, tick every 4 clk, i_tx_start pulse with 0x55: o_tx low 16 ticks, then 1,0,1,0,1,0,1,0 at 16 ticks each, high 16 ticks. Busy spans 160 ticks; one done pulse.
- Back-to-back: i_tx_start held high with 0xA3 then 0x0F. Second frame's start bit begins within 2 clk after the first done; decoded bytes are 0xA3 and 0x0F.
- PARITY_EN = 1 with 0x07: even mode gives parity bit 1 (three ones); PARITY_ODD = 1 gives 0. With STOP_BITS = 2, stop high lasts 32 ticks and the frame is 192 ticks.
- Start while busy: pulse i_tx_start with 0xFF during the 3rd data bit of a 0x00 frame. Line carries 0x00 only; a single done pulse.
- Reset mid-frame: assert reset during bit 4 of 0x3C. Next clk o_tx = 1, busy = 0, done = 0. A new 0x81 request afterwards is sent correctly.
- Loopback: connect o_tx to the receiver's RX and send 0x00, 0xFF, 0x5A. The receiver's o_rx_data matches each byte and done counts equal 3 on both sides.
